// File: rtl/demux_pkg.sv
// Shared definitions for the 1:4 stream demultiplexer and its per-lane FIFOs.
package demux_pkg;

  localparam int LANES = 4;
  localparam int DEPTH = 2;

  typedef logic [1:0] lane_sel_t;
  typedef logic [1:0] lane_count_t;

endpackage

// File: rtl/demux_lane_fifo.sv
// Two-entry FIFO for one output lane. The head entry is presented directly
// from storage so the lane output is registered (no path from push to head).
module demux_lane_fifo
  import demux_pkg::*;
#(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [width-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic             full,
  output logic [width-1:0] head_data
);

  logic [width-1:0] mem_r [DEPTH];
  lane_count_t      count_r;
  logic             wr_ptr_r;
  logic             rd_ptr_r;
  logic             push_s;
  logic             pop_s;

  // Qualify handshakes locally so the lane can never overflow or underflow.
  always_comb begin
    push_s = push & ~full;
    pop_s  = pop & valid;
  end

  // Status and head word derived from the registered count and read pointer;
  // the head reads as zero while the lane is empty.
  always_comb begin
    valid = (count_r != 2'd0);
    full  = (count_r == 2'd2);
    if (valid) begin
      head_data = mem_r[rd_ptr_r];
    end else begin
      head_data = {width{1'b0}};
    end
  end

  // Storage, pointer and occupancy update; reset discards every buffered word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {width{1'b0}};
      end
      count_r  <= 2'd0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/demux4_stream.sv
// 1:4 stream router: one valid/ready input steered by in_sel into one of four
// independently buffered output lanes. A stalled lane only blocks words bound
// for that lane.
module demux4_stream
  import demux_pkg::*;
#(
  parameter int width = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  input  logic [1:0]             in_sel,
  input  logic [width-1:0]       in_data,
  output logic                   in_ready,
  output logic [LANES-1:0]       out_valid,
  output logic [LANES*width-1:0] out_data,
  input  logic [LANES-1:0]       out_ready,
  output logic [LANES-1:0]       lane_full
);

  logic [LANES-1:0] push_s;
  logic [width-1:0] head_s [LANES];

  // Input acceptance depends only on the selected lane's fill state, never on
  // any consumer's ready.
  always_comb begin
    in_ready = ~lane_full[in_sel];
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign push_s[k] = in_valid & in_ready & (lane_sel_t'(in_sel) == lane_sel_t'(k));

    demux_lane_fifo #(.width(width)) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push_s[k]),
      .push_data (in_data),
      .pop       (out_ready[k]),
      .valid     (out_valid[k]),
      .full      (lane_full[k]),
      .head_data (head_s[k])
    );

    assign out_data[k*width +: width] = head_s[k];
  end

endmodule

// File: doc/demux4_stream.md
Name: demux4_stream

Overview:
- 1:4 routing block, the distribution counterpart of the mux4 selector: one valid/ready input stream is steered to one of four output lanes by a 2-bit destination select.
- Each lane has a 2-entry FIFO, so a stalled lane never blocks traffic bound for the other lanes.
- Intended use: fan-out of memory/bus responses to four consumers in the datapath.

Parameters:
- width, 32, data width of the input and each output lane.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input word present.
- in_sel  input  2  destination lane (0..3) for the current input word.
- in_data  input  width  input word.
- in_ready  output  1  block can accept the input word this cycle.
- out_valid  output  4  per-lane head-of-FIFO valid.
- out_data  output  4*width  lane k occupies bits [k*width +: width].
- out_ready  input  4  per-lane consumer ready.
- lane_full  output  4  per-lane FIFO holds 2 entries.

Behaviour:
- Reset: asserting reset_n low immediately clears all lane counts and read/write pointers, with no clock edge required.
  - Output values during and after reset: out_valid=4'b0000, lane_full=4'b0000, in_ready=1, out_data=0.
  - Reset asserted mid-transfer discards every buffered word. No partial state survives.
- Input handshake:
  - in_ready = ~lane_full[in_sel]. This is purely combinational from the selected lane's count and in_sel, and never depends on out_ready.
  - A push occurs when in_valid && in_ready at a rising edge. The word is written to lane in_sel only; the other lanes are unaffected.
  - in_sel and in_data are sampled only on a push. While in_ready=0, the source holds them stable; the block does not require this.
- Output handshake, per lane k:
  - out_valid[k] = (count[k] != 0).
  - out_data lane k = the oldest entry in lane k.
  - A pop occurs when out_valid[k] && out_ready[k] at a rising edge.
- Latency: a word pushed at edge N is visible on out_valid/out_data at the same lane after edge N (registered, 1 cycle). There is no combinational in→out path.
- Per-lane FIFO:
  - Depth 2, 2-bit count (0..2), 1-bit read and write pointers that wrap 1→0.
  - Strict FIFO order within a lane. Across lanes there is no ordering guarantee.
- Simultaneous push and pop on the same lane:
  - count 1: both happen; count stays 1; head advances to the new word.
  - count 0: push only; a pop is impossible because out_valid=0.
  - count 2: push blocked because in_ready=0; pop proceeds; count→1. in_ready for that lane rises the following cycle, not the same cycle.
- Push on lane j and pops on any other lanes in the same cycle are fully independent.
- All four lanes may pop in the same cycle.
- Overflow and underflow are impossible by construction. Out-of-range select cannot occur (2-bit).
- Full throughput: 1 word/cycle into any lane whose consumer holds out_ready=1 continuously.

Decomposition:
- Shared package demux_pkg:
  - localparam LANES=4, DEPTH=2.
  - typedef lane_sel_t (logic [1:0]).
- One sub-module demux_lane_fifo #(width):
  - Ports: clk, reset_n, push, push_data, pop, valid, full, head_data. Same async active-low reset.
- demux4_stream instantiates it 4× via generate. The top level contains only:
  - select decode: push_k = in_valid & in_ready & (in_sel==k);
  - in_ready selection;
  - output packing.

Test Plan:
- Reset: hold reset_n=0 asynchronously mid-cycle with 2 words buffered in lane 1 → out_valid=0000, lane_full=0000, in_ready=1 immediately, before any clock edge; after release, lane 1 stays empty.
- Routing: push 0xA0 sel=0, 0xB1 sel=1, 0xC2 sel=2, 0xD3 sel=3 on consecutive cycles with out_ready=1111 → each word appears exactly once, on its own lane only, 1 cycle after its push.
- Backpressure/order: out_ready[2]=0, push 0x11, 0x22, 0x33 to lane 2.
  - After 2 pushes: lane_full[2]=1 and in_ready=0 for sel=2 (0x33 held); in_ready=1 when sel is switched to 0.
  - Raise out_ready[2] → 0x11 then 0x22 then 0x33 delivered, in order.
- Isolation: lane 3 full and stalled; stream 8 words to lane 0 with out_ready[0]=1 → lane 0 sustains 1 word/cycle; lane 3 contents unchanged.
- Same-cycle push/pop: lane 1 count=1 holding 0x55; push 0x66 with out_ready[1]=1 → 0x55 consumed, head=0x66, count stays 1, lane_full[1]=0.
- Full-lane drain: lane 0 full (0x01, 0x02), in_valid=1 sel=0 data=0x03, out_ready[0]=1 for one edge → 0x01 popped; 0x03 not accepted that edge; accepted on the next edge; final order 0x02, 0x03.
